// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request cache front end with next-PC
// redirect priority, pending-redirect latching, flush/drop handling and AdEL detection.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f_i,
  input  logic        flush_f_i,
  input  logic        epc_sel_i,
  input  logic [31:0] epc_out_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        jump_reg_i,
  input  logic [31:0] pc_src_reg_i,
  input  logic        branch_d_i,
  input  logic [31:0] branch_addr_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] instr_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus_4_f_o,
  output logic        valid_f_o,
  output logic        adel_f_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic        inst_req_q;
  logic [31:0] inst_addr_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus_4_q;
  logic        valid_q;
  logic        adel_q;
  logic        drop_q;
  logic        pend_valid_q;
  logic [2:0]  pend_pri_q;
  logic [31:0] pend_pc_q;

  logic [2:0]  cur_pri;
  logic [31:0] cur_pc;
  logic        use_cur;
  logic [31:0] next_pc_d;
  logic        misaligned;
  logic        accept;
  logic        capture;
  logic        discard;
  logic        hold_go;
  logic        retarget;
  logic        load;

  // Redirect sources encoded by priority level so a pending one can be out-ranked.
  always_comb begin
    cur_pri = 3'd0;
    cur_pc  = 32'd0;
    if (flush_f_i) begin
      cur_pri = 3'd5;
      cur_pc  = EXC_VECTOR;
    end else if (epc_sel_i) begin
      cur_pri = 3'd4;
      cur_pc  = epc_out_i;
    end else if (jump_reg_i) begin
      cur_pri = 3'd3;
      cur_pc  = pc_src_reg_i;
    end else if (jump_i) begin
      cur_pri = 3'd2;
      cur_pc  = jump_addr_i;
    end else if (branch_d_i) begin
      cur_pri = 3'd1;
      cur_pc  = branch_addr_i;
    end
  end

  assign use_cur    = (cur_pri != 3'd0) && (!pend_valid_q || (cur_pri >= pend_pri_q));
  assign next_pc_d  = use_cur ? cur_pc : (pend_valid_q ? pend_pc_q : fetch_pc_q + 32'd4);
  assign misaligned = |fetch_pc_q[1:0];
  assign accept     = (state_q == REQ) && inst_req_q && inst_addr_ok_i;
  // A misaligned PC never reaches the cache; it completes like a returned word.
  assign capture    = ((state_q == WAIT) && inst_data_ok_i) ||
                      ((state_q == REQ) && ((accept && inst_data_ok_i) || misaligned));
  assign discard    = capture && (flush_f_i || drop_q);
  assign hold_go    = (state_q == HOLD) && (!stall_f_i || flush_f_i);
  assign retarget   = (state_q == REQ) && flush_f_i && !accept && !misaligned;
  assign load       = (capture && (discard || !stall_f_i)) || hold_go || retarget;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      inst_req_q   <= 1'b0;
      inst_addr_q  <= RESET_PC;
      instr_q      <= 32'd0;
      pc_q         <= 32'd0;
      pc_plus_4_q  <= 32'd0;
      valid_q      <= 1'b0;
      adel_q       <= 1'b0;
      drop_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pri_q   <= 3'd0;
      pend_pc_q    <= 32'd0;
    end else begin
      if (load) begin
        state_q      <= REQ;
        fetch_pc_q   <= next_pc_d;
        inst_addr_q  <= next_pc_d;
        inst_req_q   <= ~|next_pc_d[1:0];
        pend_valid_q <= 1'b0;
        pend_pri_q   <= 3'd0;
      end else begin
        if (use_cur) begin
          pend_valid_q <= 1'b1;
          pend_pri_q   <= cur_pri;
          pend_pc_q    <= cur_pc;
        end
        case (state_q)
          IDLE: begin
            state_q     <= REQ;
            fetch_pc_q  <= RESET_PC;
            inst_addr_q <= RESET_PC;
            inst_req_q  <= ~|RESET_PC[1:0];
          end
          REQ: begin
            if (capture) begin
              state_q    <= HOLD;
              inst_req_q <= 1'b0;
            end else if (accept) begin
              state_q    <= WAIT;
              inst_req_q <= 1'b0;
            end
          end
          WAIT: begin
            if (capture) state_q <= HOLD;
          end
          default: state_q <= HOLD;
        endcase
      end

      if (capture)
        drop_q <= 1'b0;
      else if (flush_f_i && ((state_q == WAIT) || accept))
        drop_q <= 1'b1;

      if (capture && !discard) begin
        valid_q     <= 1'b1;
        adel_q      <= misaligned;
        instr_q     <= misaligned ? 32'd0 : inst_rdata_i;
        pc_q        <= fetch_pc_q;
        pc_plus_4_q <= fetch_pc_q + 32'd4;
      end else if (!stall_f_i || flush_f_i) begin
        valid_q <= 1'b0;
        adel_q  <= 1'b0;
      end
    end
  end

  assign inst_req_o    = inst_req_q;
  assign inst_addr_o   = inst_addr_q;
  assign instr_f_o     = instr_q;
  assign pc_f_o        = pc_q;
  assign pc_plus_4_f_o = pc_plus_4_q;
  assign valid_f_o     = valid_q;
  assign adel_f_o      = adel_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: plays the instruction cache and predicts each fetch
// address from a transaction-level redirect-priority model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC      = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f_i, flush_f_i, epc_sel_i, jump_i, jump_reg_i, branch_d_i;
  logic [31:0] epc_out_i, jump_addr_i, pc_src_reg_i, branch_addr_i;
  logic        inst_req_o, inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_addr_o, inst_rdata_i;
  logic [31:0] instr_f_o, pc_f_o, pc_plus_4_f_o;
  logic        valid_f_o, adel_f_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: next fetch address = highest-priority redirect seen since the last load, else pc+4.
  logic [31:0] exp_pc;
  int          best_pri;
  logic [31:0] best_pc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_f_i(stall_f_i), .flush_f_i(flush_f_i),
    .epc_sel_i(epc_sel_i), .epc_out_i(epc_out_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .jump_reg_i(jump_reg_i), .pc_src_reg_i(pc_src_reg_i),
    .branch_d_i(branch_d_i), .branch_addr_i(branch_addr_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i),
    .instr_f_o(instr_f_o), .pc_f_o(pc_f_o), .pc_plus_4_f_o(pc_plus_4_f_o),
    .valid_f_o(valid_f_o), .adel_f_o(adel_f_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall_f_i = 0; flush_f_i = 0; epc_sel_i = 0; jump_i = 0; jump_reg_i = 0; branch_d_i = 0;
    inst_addr_ok_i = 0; inst_data_ok_i = 0;
  endtask

  task automatic merge(input int pri, input logic [31:0] tgt);
    if (pri >= best_pri) begin
      best_pri = pri;
      best_pc  = tgt;
    end
  endtask

  task automatic advance_model();
    exp_pc   = (best_pri > 0) ? best_pc : exp_pc + 32'd4;
    best_pri = 0;
  endtask

  // kind: 1 branch, 2 jump, 3 jump-register, 4 ERET, 5 flush
  task automatic drive_redir(input int kind, input logic [31:0] tgt);
    case (kind)
      1: begin branch_d_i = 1; branch_addr_i = tgt; merge(1, tgt); end
      2: begin jump_i = 1; jump_addr_i = tgt; merge(2, tgt); end
      3: begin jump_reg_i = 1; pc_src_reg_i = tgt; merge(3, tgt); end
      4: begin epc_sel_i = 1; epc_out_i = tgt; merge(4, tgt); end
      default: begin flush_f_i = 1; merge(5, EXC); end
    endcase
  endtask

  task automatic rnd_redir(input bit en);
    logic [31:0] t;
    if (!en) return;
    for (int k = 0; k < 2; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        t = $urandom;
        t[1:0] = 2'b00;
        drive_redir(int'($urandom_range(1, 4)), t);
      end
    end
  endtask

  // fkind 6 asserts ERET, JR and J together.
  task automatic apply_force(input int fkind, input logic [31:0] fpc);
    if (fkind == 6) begin
      drive_redir(2, 32'h8000_4000);
      drive_redir(3, 32'h8000_5000);
      drive_redir(4, fpc);
    end else if (fkind > 0) begin
      drive_redir(fkind, fpc);
    end
  endtask

  task automatic do_txn(input int a_dly, input int d_dly, input bit simul, input int hold,
                        input bit rnd, input int fkind, input logic [31:0] fpc);
    int guard = 0;
    logic [31:0] rd;
    while (inst_req_o !== 1'b1 && guard < 20) begin
      clear_in();
      step();
      guard++;
    end
    check_eq("req_seen", {31'd0, inst_req_o}, 32'd1);
    for (int a = 0; a < a_dly; a++) begin
      clear_in();
      rnd_redir(rnd);
      check_eq("addr_stable", inst_addr_o, exp_pc);
      step();
    end
    clear_in();
    rnd_redir(rnd);
    inst_addr_ok_i = 1;
    check_eq("req_addr", inst_addr_o, exp_pc);
    rd = $urandom;
    if (!simul) begin
      step();
      for (int w = 0; w < d_dly; w++) begin
        clear_in();
        rnd_redir(rnd);
        if (w == 0) apply_force(fkind, fpc);
        check_eq("wait_noreq", {31'd0, inst_req_o}, 32'd0);
        step();
      end
      clear_in();
      rnd_redir(rnd);
    end
    inst_data_ok_i = 1;
    inst_rdata_i   = rd;
    stall_f_i      = (hold > 0);
    step();
    $display("txn pc=%08h instr=%08h hold=%0d", exp_pc, rd, hold);
    check_eq("valid", {31'd0, valid_f_o}, 32'd1);
    check_eq("pc_f", pc_f_o, exp_pc);
    check_eq("instr_f", instr_f_o, rd);
    check_eq("pc_plus_4", pc_plus_4_f_o, exp_pc + 32'd4);
    check_eq("adel", {31'd0, adel_f_o}, 32'd0);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        clear_in();
        stall_f_i = 1;
        rnd_redir(rnd);
        step();
        check_eq("hold_valid", {31'd0, valid_f_o}, 32'd1);
        check_eq("hold_pc", pc_f_o, exp_pc);
        check_eq("hold_instr", instr_f_o, rd);
        check_eq("hold_noreq", {31'd0, inst_req_o}, 32'd0);
      end
      clear_in();
      rnd_redir(rnd);
      step();
      check_eq("release_valid", {31'd0, valid_f_o}, 32'd0);
    end
    advance_model();
    clear_in();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    epc_out_i = 0; jump_addr_i = 0; pc_src_reg_i = 0; branch_addr_i = 0; inst_rdata_i = 0;
    clear_in();
    best_pri = 0;
    best_pc  = 0;
    exp_pc   = RESET_PC;
    repeat (3) step();
    check_eq("rst_req", {31'd0, inst_req_o}, 32'd0);
    check_eq("rst_addr", inst_addr_o, RESET_PC);
    check_eq("rst_valid", {31'd0, valid_f_o}, 32'd0);
    check_eq("rst_adel", {31'd0, adel_f_o}, 32'd0);
    check_eq("rst_pc_f", pc_f_o, 32'd0);
    check_eq("rst_instr", instr_f_o, 32'd0);
    rst_n = 1;

    // Sequential fetch from reset
    repeat (3) do_txn(0, 1, 0, 0, 0, 0, 0);
    // Taken branch while waiting for data
    do_txn(1, 2, 0, 0, 0, 1, 32'h8000_1000);
    do_txn(0, 1, 0, 0, 0, 0, 0);
    // Stall held after capture
    do_txn(0, 1, 0, 3, 0, 0, 0);

    // Flush before the request is accepted retargets immediately
    clear_in();
    drive_redir(5, EXC);
    step();
    advance_model();
    check_eq("req_flush_addr", inst_addr_o, exp_pc);
    check_eq("req_flush_req", {31'd0, inst_req_o}, 32'd1);
    clear_in();
    do_txn(0, 1, 0, 0, 0, 0, 0);

    // Flush while waiting: returned word is discarded
    clear_in();
    inst_addr_ok_i = 1;
    check_eq("req_addr", inst_addr_o, exp_pc);
    step();
    clear_in();
    drive_redir(5, EXC);
    step();
    check_eq("flush_valid0", {31'd0, valid_f_o}, 32'd0);
    clear_in();
    step();
    clear_in();
    inst_data_ok_i = 1;
    inst_rdata_i   = 32'hDEAD_BEEF;
    step();
    check_eq("drop_valid", {31'd0, valid_f_o}, 32'd0);
    advance_model();
    check_eq("exc_addr", inst_addr_o, exp_pc);
    check_eq("exc_req", {31'd0, inst_req_o}, 32'd1);
    clear_in();
    do_txn(0, 1, 0, 0, 0, 0, 0);

    // ERET to a misaligned target beats JR and J; raises AdEL without a request
    do_txn(0, 1, 0, 0, 0, 6, 32'h8000_0202);
    check_eq("adel_noreq", {31'd0, inst_req_o}, 32'd0);
    clear_in();
    drive_redir(1, 32'h8000_2000);
    step();
    check_eq("adel_flag", {31'd0, adel_f_o}, 32'd1);
    check_eq("adel_valid", {31'd0, valid_f_o}, 32'd1);
    check_eq("adel_pc_f", pc_f_o, 32'h8000_0202);
    check_eq("adel_instr", instr_f_o, 32'd0);
    check_eq("adel_next_req", {31'd0, inst_req_o}, 32'd1);
    advance_model();
    clear_in();
    do_txn(0, 1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      do_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
             1, 0, 0);
    end

    // Reset mid-request; a stale data return afterwards is ignored
    clear_in();
    inst_addr_ok_i = 1;
    step();
    clear_in();
    #2;
    rst_n = 0;
    #1;
    check_eq("abort_req", {31'd0, inst_req_o}, 32'd0);
    check_eq("abort_addr", inst_addr_o, RESET_PC);
    check_eq("abort_valid", {31'd0, valid_f_o}, 32'd0);
    check_eq("abort_pc_f", pc_f_o, 32'd0);
    step();
    rst_n = 1;
    inst_data_ok_i = 1;
    inst_rdata_i   = 32'h1234_5678;
    step();
    check_eq("stale_valid", {31'd0, valid_f_o}, 32'd0);
    check_eq("restart_req", {31'd0, inst_req_o}, 32'd1);
    check_eq("restart_addr", inst_addr_o, RESET_PC);
    clear_in();
    exp_pc   = RESET_PC;
    best_pri = 0;
    do_txn(0, 1, 0, 0, 0, 0, 0);
    do_txn(0, 0, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
